// File: rtl/frontend_ctrl_pkg.sv
// Shared definitions for the frontend control logic.
//   sweep_state_t : resonance sweep FSM states
//   ACC_W / MAG_W : correlation accumulator width and |sin|+|cos| width
//   abs_ext       : absolute value of a signed accumulator, returned unsigned
package frontend_ctrl_pkg;

    localparam int ACC_W = 36;
    localparam int MAG_W = ACC_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROGRAM,
        ST_SETTLE,
        ST_MEASURE,
        ST_FINISH
    } sweep_state_t;

    // Two's-complement negate read back as unsigned: the most-negative input
    // maps to 2^(ACC_W-1), which still fits in ACC_W unsigned bits.
    function automatic logic [ACC_W-1:0] abs_ext(input logic signed [ACC_W-1:0] i_val);
        logic [ACC_W-1:0] w_u;
        w_u = i_val;
        return w_u[ACC_W-1] ? ((~w_u) + ACC_W'(1)) : w_u;
    endfunction

endpackage

// File: rtl/acc_magnitude.sv
// Combinational |a| + |b| of two signed correlation accumulators.
//   i_a, i_b : signed ACC_W-bit inputs
//   o_mag    : unsigned ACC_W+1-bit magnitude sum (cannot overflow)
module acc_magnitude
    import frontend_ctrl_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic        [MAG_W-1:0] o_mag
);

    assign o_mag = {1'b0, abs_ext(i_a)} + {1'b0, abs_ext(i_b)};

endmodule

// File: rtl/resonance_sweep_controller.sv
// Steps the frontend phase increment through a sweep, waits a settle time at
// each point, keeps the point with the largest |sin|+|cos| and finally
// reprograms the frontend to that best increment.
//   i_clk, i_reset (sync, active-high), i_ce (clock enable)
//   i_start / i_abort                : sweep control
//   i_sweep_* / i_settle_cycles      : sweep configuration, latched at start
//   i_sin_mul_acc / i_cos_mul_acc    : signed frontend correlation results
//   o_phase_increment_out(_we)       : increment write port to the frontend
//   o_busy / o_done                  : status, o_done is a one-cycle pulse
//   o_peak_phase_increment/_magnitude: result of the last completed sweep
module resonance_sweep_controller
    import frontend_ctrl_pkg::*;
#(
    parameter int PHASE_INCREMENT_BITS = 28,
    parameter int RESULT_MUL_ACC_WIDTH = ACC_W,
    parameter int STEP_COUNT_BITS      = 10,
    parameter int SETTLE_BITS          = 16
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_ce,
    input  logic                              i_start,
    input  logic                              i_abort,
    input  logic [PHASE_INCREMENT_BITS-1:0]   i_sweep_start_inc,
    input  logic [PHASE_INCREMENT_BITS-1:0]   i_sweep_step_inc,
    input  logic [STEP_COUNT_BITS-1:0]        i_sweep_points,
    input  logic [SETTLE_BITS-1:0]            i_settle_cycles,
    input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] i_sin_mul_acc,
    input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] i_cos_mul_acc,
    output logic [PHASE_INCREMENT_BITS-1:0]   o_phase_increment_out,
    output logic                              o_phase_increment_out_we,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [PHASE_INCREMENT_BITS-1:0]   o_peak_phase_increment,
    output logic [RESULT_MUL_ACC_WIDTH:0]     o_peak_magnitude
);

    localparam int MAG_BITS = RESULT_MUL_ACC_WIDTH + 1;

    sweep_state_t r_state, w_next_state;

    logic [PHASE_INCREMENT_BITS-1:0] r_step_inc, r_cur_inc, r_best_inc;
    logic [PHASE_INCREMENT_BITS-1:0] r_phase_hold, r_peak_inc, w_phase_out;
    logic [STEP_COUNT_BITS-1:0]      r_points, r_index;
    logic [SETTLE_BITS-1:0]          r_settle, r_cnt;
    logic [MAG_BITS-1:0]             r_best_mag, r_peak_mag, w_mag;
    logic                            w_we, w_done, w_last_point;

    acc_magnitude u_mag (
        .i_a   (i_sin_mul_acc),
        .i_b   (i_cos_mul_acc),
        .o_mag (w_mag)
    );

    assign w_last_point = (r_index == (r_points - STEP_COUNT_BITS'(1)));

    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_done       = 1'b0;
        w_phase_out  = r_phase_hold;
        // The write port shows the value being programmed in the strobe
        // states and otherwise holds the last value actually written.
        case (r_state)
            ST_PROGRAM: w_phase_out = r_cur_inc;
            ST_FINISH:  w_phase_out = r_best_inc;
            default:    ;
        endcase
        if (i_ce && i_abort) begin
            w_next_state = ST_IDLE;
        end else if (i_ce) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start)
                        w_next_state = (i_sweep_points == '0) ? ST_FINISH : ST_PROGRAM;
                end
                ST_PROGRAM: begin
                    w_we         = 1'b1;
                    w_next_state = (r_settle == '0) ? ST_MEASURE : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_BITS'(1))
                        w_next_state = ST_MEASURE;
                end
                ST_MEASURE: begin
                    w_next_state = w_last_point ? ST_FINISH : ST_PROGRAM;
                end
                ST_FINISH: begin
                    w_we         = 1'b1;
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_step_inc   <= '0;
            r_cur_inc    <= '0;
            r_best_inc   <= '0;
            r_phase_hold <= '0;
            r_peak_inc   <= '0;
            r_points     <= '0;
            r_index      <= '0;
            r_settle     <= '0;
            r_cnt        <= '0;
            r_best_mag   <= '0;
            r_peak_mag   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_we)
                r_phase_hold <= w_phase_out;
            if (i_ce && !i_abort) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_step_inc <= i_sweep_step_inc;
                            r_points   <= i_sweep_points;
                            r_settle   <= i_settle_cycles;
                            r_cur_inc  <= i_sweep_start_inc;
                            r_best_inc <= i_sweep_start_inc;
                            r_best_mag <= '0;
                            r_index    <= '0;
                        end
                    end
                    ST_PROGRAM: r_cnt <= r_settle;
                    ST_SETTLE:  r_cnt <= r_cnt - SETTLE_BITS'(1);
                    ST_MEASURE: begin
                        // Strict compare: on a tie the earlier point wins.
                        if (w_mag > r_best_mag) begin
                            r_best_mag <= w_mag;
                            r_best_inc <= r_cur_inc;
                        end
                        if (!w_last_point) begin
                            r_index   <= r_index + STEP_COUNT_BITS'(1);
                            r_cur_inc <= r_cur_inc + r_step_inc;
                        end
                    end
                    ST_FINISH: begin
                        r_peak_inc <= r_best_inc;
                        r_peak_mag <= r_best_mag;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_phase_increment_out    = w_phase_out;
    assign o_phase_increment_out_we = w_we;
    assign o_done                   = w_done;
    assign o_busy                   = (r_state != ST_IDLE);
    assign o_peak_phase_increment   = r_peak_inc;
    assign o_peak_magnitude         = r_peak_mag;

endmodule
